demux_pipe: RTL and testbench
=============================

DEMUX_PIPE -- requirements
Module: demux_pipe

Interface
REQ-001 The block SHALL have one parameter: data_bits, default 31, giving the data MSB index (data width = data_bits+1).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 sinal  input  1  route select: 0 = output 1, 1 = output 2; sampled with in_data.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  block accepts word this cycle.
REQ-007 in_data  input  data_bits+1  upstream word.
REQ-008 out_valid1 / out_valid2  output  1 each  head word present at output 1 / 2.
REQ-009 out_ready1 / out_ready2  input  1 each  downstream consumer 1 / 2 takes head word.
REQ-010 out_data1 / out_data2  output  data_bits+1 each  head word of output 1 / 2.
REQ-011 cnt1 / cnt2  output  16 each  routed-word counters (present only with DEMUX_STATS_EN, REQ-030).

Function
REQ-012 Each output SHALL own an independent 2-entry FIFO (storage, 1-bit write ptr, 1-bit read ptr, 2-bit count 0..2).
REQ-013 Accept SHALL occur when in_valid && in_ready at posedge clk; the word SHALL be written to the FIFO selected by sinal in that cycle.
REQ-014 in_ready SHALL be combinational: (sinal==0) ? (count1<2) : (count2<2); it SHALL NOT depend on out_ready of the same cycle (no pass-through when full).
REQ-015 out_validN SHALL equal (countN!=0); out_dataN SHALL be the entry at read ptr N, driven from registers.
REQ-016 Pop SHALL occur on output N when out_validN && out_readyN at posedge clk; read ptr N SHALL advance modulo 2.
REQ-017 Latency: a word accepted at edge k SHALL appear on out_validN/out_dataN after edge k when FIFO N was empty (1 cycle), else behind older words in order.
REQ-018 Ordering: words routed to the same output SHALL leave in acceptance order; no ordering between outputs is guaranteed.
REQ-019 Simultaneous push and pop on the same FIFO SHALL leave count unchanged and both pointers advanced.
REQ-020 Push to one FIFO and pop from the other in the same cycle SHALL be handled independently.
REQ-021 Pointers SHALL wrap 1->0; count SHALL never exceed 2 nor underflow below 0.
REQ-022 A word SHALL never be dropped, duplicated, or written to the non-selected FIFO.
REQ-023 out_readyN asserted while out_validN=0 SHALL have no effect.
REQ-024 Changing sinal while in_valid=0 SHALL have no effect on state.

Reset
REQ-025 rst=1 SHALL immediately (without clk) clear all counts and pointers, forcing out_valid1=out_valid2=0.
REQ-026 Under reset out_data1/out_data2 SHALL read 0 (storage cleared).
REQ-027 Reset asserted mid-operation SHALL discard all buffered words; no accept or pop SHALL occur while rst=1.
REQ-028 First accept SHALL be possible on the first posedge clk after rst deasserts.
REQ-029 in_ready SHALL be 1 after reset (both FIFOs empty).

Configuration
REQ-030 With macro DEMUX_STATS_EN defined, cnt1/cnt2 SHALL exist, reset to 0, increment by 1 on each accept routed to output 1/2, and wrap 16'hFFFF->0.
REQ-031 Without DEMUX_STATS_EN, cnt1/cnt2 ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Reset then in_valid=1, sinal=0, in_data=32'h1234_5678, out_ready1=0 -> next cycle out_valid1=1, out_data1=32'h1234_5678, out_valid2=0.
REQ-033 Push A,B to output 2 with out_ready2=0 -> count2=2, in_ready=0 when sinal=1, in_ready=1 when sinal=0; third word with sinal=1 not accepted.
REQ-034 Output 2 full, out_ready2=1 and in_valid=1,sinal=1 same cycle -> no accept that cycle; A popped; next cycle word accepted, order B then new word.
REQ-035 Alternate sinal 0,1,0,1 with words 1..4 and both ready=1 -> output 1 sees 1,3; output 2 sees 2,4; each 1 cycle after acceptance.
REQ-036 Two words buffered in FIFO 1, assert rst asynchronously mid-cycle -> out_valid1 drops before next clk, out_data1=0, in_ready=1.
REQ-037 DEMUX_STATS_EN defined, route 5 words to output 1 and 3 to output 2 -> cnt1=5, cnt2=3; with cnt1 preloaded to 16'hFFFF by 65535 routes, one more -> cnt1=0.

Source files
------------

// File: rtl/demux_pipe.sv
// rtl/demux_pipe.sv - 1-to-2 stream demultiplexer, one 2-entry FIFO per output
//
// Purpose:
//   Routes each accepted upstream word to output 1 (sinal=0) or output 2
//   (sinal=1). Each output is buffered by its own 2-entry FIFO, so a
//   stalled consumer only blocks words steered towards it.
//
// Ports:
//   clk          sole clock, all state updates on posedge
//   rst          asynchronous, active-high reset
//   sinal        route select, sampled together with in_data
//   in_valid     upstream word present
//   in_ready     selected FIFO has room (does not look at out_ready)
//   in_data      upstream word, data_bits+1 wide
//   out_valid1/2 FIFO 1/2 holds at least one word
//   out_ready1/2 consumer 1/2 takes the head word
//   out_data1/2  head word of FIFO 1/2, straight from storage registers
//   cnt1/cnt2    16-bit routed-word counters (only with DEMUX_STATS_EN)
//
// Configuration:
//   DEMUX_STATS_EN  when defined, adds the cnt1/cnt2 ports and counters.

module demux_pipe #(
  parameter int data_bits = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sinal,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [data_bits:0] in_data,
  output logic               out_valid1,
  output logic               out_valid2,
  input  logic               out_ready1,
  input  logic               out_ready2,
  output logic [data_bits:0] out_data1,
  output logic [data_bits:0] out_data2
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0]        cnt1,
  output logic [15:0]        cnt2
`endif
);

  // Per-FIFO control, bit 0 = output 1, bit 1 = output 2.
  logic [1:0]         w_route;
  logic [1:0]         w_push;
  logic [1:0]         w_pop;
  logic [1:0]         w_oready;
  logic [1:0]         w_not_full;
  logic [1:0]         w_not_empty;
  logic [data_bits:0] w_head [0:1];
  logic               w_accept;

  assign w_route  = {sinal, ~sinal};
  assign w_oready = {out_ready2, out_ready1};

  // Readiness only reflects the selected FIFO's occupancy; a pop in the
  // same cycle does not free a slot early, so a full FIFO never passes
  // a word through combinationally.
  assign in_ready = sinal ? w_not_full[1] : w_not_full[0];
  assign w_accept = in_valid & in_ready;
  assign w_push   = w_route & {2{w_accept}};
  assign w_pop    = w_not_empty & w_oready;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [data_bits:0] r_mem [0:1];
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_count;

    assign w_not_full[g]  = (r_count != 2'd2);
    assign w_not_empty[g] = (r_count != 2'd0);
    assign w_head[g]      = r_mem[r_rptr];

    // Storage is cleared on reset too, so the outputs read 0 under reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_mem[0] <= '0;
        r_mem[1] <= '0;
        r_wptr   <= 1'b0;
        r_rptr   <= 1'b0;
        r_count  <= 2'd0;
      end else begin
        if (w_push[g]) begin
          r_mem[r_wptr] <= in_data;
          r_wptr        <= ~r_wptr;
        end
        if (w_pop[g]) begin
          r_rptr <= ~r_rptr;
        end
        // Push and pop together leave the occupancy unchanged.
        case ({w_push[g], w_pop[g]})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign out_valid1 = w_not_empty[0];
  assign out_valid2 = w_not_empty[1];
  assign out_data1  = w_head[0];
  assign out_data2  = w_head[1];

`ifdef DEMUX_STATS_EN
  logic [15:0] r_cnt1;
  logic [15:0] r_cnt2;

  // Free-running counters of accepted words per destination; wrap at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt1 <= 16'd0;
      r_cnt2 <= 16'd0;
    end else begin
      if (w_push[0]) begin
        r_cnt1 <= r_cnt1 + 16'd1;
      end
      if (w_push[1]) begin
        r_cnt2 <= r_cnt2 + 16'd1;
      end
    end
  end

  assign cnt1 = r_cnt1;
  assign cnt2 = r_cnt2;
`endif

endmodule

// File: tb/tb_demux_pipe.sv
// tb/tb_demux_pipe.sv - self-checking bench for demux_pipe

module tb_demux_pipe;

  logic        clk;
  logic        rst;
  logic        sinal;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid1;
  logic        out_valid2;
  logic        out_ready1;
  logic        out_ready2;
  logic [31:0] out_data1;
  logic [31:0] out_data2;
`ifdef DEMUX_STATS_EN
  logic [15:0] cnt1;
  logic [15:0] cnt2;
`endif

  int n_checks;
  int n_errors;

  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [15:0] m_cnt1;
  logic [15:0] m_cnt2;

  demux_pipe #(.data_bits(31)) dut (
    .clk        (clk),
    .rst        (rst),
    .sinal      (sinal),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid1 (out_valid1),
    .out_valid2 (out_valid2),
    .out_ready1 (out_ready1),
    .out_ready2 (out_ready2),
    .out_data1  (out_data1),
    .out_data2  (out_data2)
`ifdef DEMUX_STATS_EN
    ,
    .cnt1       (cnt1),
    .cnt2       (cnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: two bounded queues updated from the inputs held
  // across the coming posedge, then returns at the following negedge.
  task automatic tick();
    bit acc, p1, p2;
    acc = !rst && in_valid && (sinal ? (q2.size() < 2) : (q1.size() < 2));
    p1  = !rst && out_ready1 && (q1.size() > 0);
    p2  = !rst && out_ready2 && (q2.size() > 0);
    @(posedge clk);
    if (rst) begin
      q1.delete();
      q2.delete();
      m_cnt1 = 16'd0;
      m_cnt2 = 16'd0;
    end else begin
      if (p1) void'(q1.pop_front());
      if (p2) void'(q2.pop_front());
      if (acc) begin
        if (sinal) begin
          q2.push_back(in_data);
          m_cnt2 = m_cnt2 + 16'd1;
        end else begin
          q1.push_back(in_data);
          m_cnt1 = m_cnt1 + 16'd1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    sinal      = 1'b0;
    in_data    = '0;
    out_ready1 = 1'b0;
    out_ready2 = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    q1.delete();
    q2.delete();
    m_cnt1 = 16'd0;
    m_cnt2 = 16'd0;
    n_checks++;
    if (out_valid1 !== 1'b0) begin n_errors++; $display("FAIL reset_valid1 got %b want 0", out_valid1); end
    n_checks++;
    if (out_valid2 !== 1'b0) begin n_errors++; $display("FAIL reset_valid2 got %b want 0", out_valid2); end
    n_checks++;
    if (out_data1 !== 32'h0) begin n_errors++; $display("FAIL reset_data1 got %h want 0", out_data1); end
    n_checks++;
    if (out_data2 !== 32'h0) begin n_errors++; $display("FAIL reset_data2 got %h want 0", out_data2); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_first_word();
    in_valid = 1'b1;
    sinal    = 1'b0;
    in_data  = 32'h1234_5678;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL first_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid1 !== 1'b1) begin n_errors++; $display("FAIL first_valid1 got %b want 1", out_valid1); end
    n_checks++;
    if (out_data1 !== 32'h1234_5678) begin n_errors++; $display("FAIL first_data1 got %h want 12345678", out_data1); end
    n_checks++;
    if (out_valid2 !== 1'b0) begin n_errors++; $display("FAIL first_valid2 got %b want 0", out_valid2); end
    // ready on an empty output must be harmless
    out_ready2 = 1'b1;
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    out_ready2 = 1'b0;
    #1;
    n_checks++;
    if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0) begin
      n_errors++; $display("FAIL first_drain got %b%b want 00", out_valid1, out_valid2);
    end
  endtask

  task automatic test_full();
    in_valid = 1'b1;
    sinal    = 1'b1;
    in_data  = 32'hAAAA_0001;
    tick();
    in_data  = 32'hBBBB_0002;
    tick();
    in_data  = 32'hCCCC_0003;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready_sel2 got %b want 0", in_ready); end
    sinal = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL full_ready_sel1 got %b want 1", in_ready); end
    sinal = 1'b1;
    in_valid = 1'b1;
    tick();
    n_checks++;
    if (out_data2 !== 32'hAAAA_0001 || out_valid1 !== 1'b0) begin
      n_errors++; $display("FAIL full_no_accept got %h v1=%b want aaaa0001 v1=0", out_data2, out_valid1);
    end
    // pop and blocked push in the same cycle
    in_data    = 32'hDDDD_0004;
    out_ready2 = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL full_no_passthru got %b want 0", in_ready); end
    tick();
    out_ready2 = 1'b0;
    #1;
    n_checks++;
    if (out_data2 !== 32'hBBBB_0002 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL full_after_pop got %h rdy=%b want bbbb0002 rdy=1", out_data2, in_ready);
    end
    tick();
    in_valid   = 1'b0;
    out_ready2 = 1'b1;
    #1;
    n_checks++;
    if (out_data2 !== 32'hBBBB_0002) begin n_errors++; $display("FAIL full_order0 got %h want bbbb0002", out_data2); end
    tick();
    n_checks++;
    if (out_data2 !== 32'hDDDD_0004 || out_valid2 !== 1'b1) begin
      n_errors++; $display("FAIL full_order1 got %h v=%b want dddd0004 v=1", out_data2, out_valid2);
    end
    tick();
    out_ready2 = 1'b0;
    #1;
    n_checks++;
    if (out_valid2 !== 1'b0) begin n_errors++; $display("FAIL full_empty got %b want 0", out_valid2); end
  endtask

  task automatic test_alternate();
    out_ready1 = 1'b1;
    out_ready2 = 1'b1;
    in_valid   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      sinal   = ((i % 2) == 0);
      in_data = i;
      tick();
      #1;
      n_checks++;
      if ((i % 2) == 1) begin
        if (out_valid1 !== 1'b1 || out_data1 !== i) begin
          n_errors++; $display("FAIL alt_word%0d out1 got v=%b %h want v=1 %h", i, out_valid1, out_data1, i);
        end
      end else begin
        if (out_valid2 !== 1'b1 || out_data2 !== i) begin
          n_errors++; $display("FAIL alt_word%0d out2 got v=%b %h want v=1 %h", i, out_valid2, out_data2, i);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0) begin
      n_errors++; $display("FAIL alt_drain got %b%b want 00", out_valid1, out_valid2);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    sinal    = 1'b0;
    in_data  = 32'h5555_0001;
    tick();
    in_data  = 32'h5555_0002;
    tick();
    in_valid = 1'b1;
    in_data  = 32'h5555_0003;
    sinal    = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid1 !== 1'b0 || out_data1 !== 32'h0 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL async_rst got v=%b d=%h rdy=%b want 0 0 1", out_valid1, out_data1, in_ready);
    end
    // inputs stay active while in reset: nothing may be accepted
    tick();
    #1;
    n_checks++;
    if (out_valid2 !== 1'b0) begin n_errors++; $display("FAIL rst_no_accept got %b want 0", out_valid2); end
    rst     = 1'b0;
    in_data = 32'h7777_0007;
    tick();
    #1;
    n_checks++;
    if (out_valid2 !== 1'b1 || out_data2 !== 32'h7777_0007) begin
      n_errors++; $display("FAIL post_rst_accept got v=%b %h want v=1 77770007", out_valid2, out_data2);
    end
    do_reset();
    q1.delete();
    q2.delete();
    m_cnt1 = 16'd0;
    m_cnt2 = 16'd0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      sinal      = $urandom_range(0, 1);
      in_data    = $urandom;
      out_ready1 = ($urandom_range(0, 2) != 0);
      out_ready2 = ($urandom_range(0, 2) == 0);
      #1;
      n_checks++;
      if (in_ready !== (sinal ? (q2.size() < 2) : (q1.size() < 2))) begin
        n_errors++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", c, in_ready, !in_ready);
      end
      n_checks++;
      if (out_valid1 !== (q1.size() != 0) || out_valid2 !== (q2.size() != 0)) begin
        n_errors++; $display("FAIL rnd_valid cyc %0d got %b%b want %0d%0d", c, out_valid2, out_valid1, q2.size() != 0, q1.size() != 0);
      end
      if (q1.size() != 0) begin
        n_checks++;
        if (out_data1 !== q1[0]) begin n_errors++; $display("FAIL rnd_data1 cyc %0d got %h want %h", c, out_data1, q1[0]); end
      end
      if (q2.size() != 0) begin
        n_checks++;
        if (out_data2 !== q2[0]) begin n_errors++; $display("FAIL rnd_data2 cyc %0d got %h want %h", c, out_data2, q2[0]); end
      end
`ifdef DEMUX_STATS_EN
      n_checks++;
      if (cnt1 !== m_cnt1 || cnt2 !== m_cnt2) begin
        n_errors++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d want %0d/%0d", c, cnt1, cnt2, m_cnt1, m_cnt2);
      end
`endif
      tick();
    end
    idle_inputs();
  endtask

`ifdef DEMUX_STATS_EN
  task automatic test_stats();
    do_reset();
    q1.delete();
    q2.delete();
    m_cnt1 = 16'd0;
    m_cnt2 = 16'd0;
    out_ready1 = 1'b1;
    out_ready2 = 1'b1;
    in_valid   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sinal   = (i >= 5);
      in_data = i;
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (cnt1 !== 16'd5 || cnt2 !== 16'd3) begin
      n_errors++; $display("FAIL stats_5_3 got %0d/%0d want 5/3", cnt1, cnt2);
    end
    in_valid = 1'b1;
    sinal    = 1'b0;
    for (int i = 0; i < 65530; i++) begin
      in_data = i;
      tick();
    end
    #1;
    n_checks++;
    if (cnt1 !== 16'hFFFF) begin n_errors++; $display("FAIL stats_ffff got %h want ffff", cnt1); end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (cnt1 !== 16'h0000 || cnt2 !== 16'd3) begin
      n_errors++; $display("FAIL stats_wrap got %h/%0d want 0000/3", cnt1, cnt2);
    end
    idle_inputs();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_first_word();
    test_full();
    test_alternate();
    test_async_reset();
    test_random();
`ifdef DEMUX_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
